alu_result_serializer: RTL and testbench
========================================

ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

Interface
REQ-001 SHALL have parameter width, default 8, meaning byte width; the result width is 2*width.
REQ-002 SHALL have port CLK  input  1  system clock; all logic is rising-edge.
REQ-003 SHALL have port RST_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ALU_OUT  input  2*width  ALU result word.
REQ-005 SHALL have port OUT_VALID  input  1  ALU_OUT is valid this cycle (one-cycle pulse per result).
REQ-006 SHALL have port TX_BUSY  input  1  downstream transmitter cannot accept a byte this cycle.
REQ-007 SHALL have port TX_P_DATA  output  width  byte presented to the transmitter.
REQ-008 SHALL have port TX_D_VALID  output  1  TX_P_DATA is valid.
REQ-009 SHALL have port RES_READY  output  1  result buffer has a free entry.
REQ-010 SHALL have port OVERRUN  output  1  sticky flag: a result was dropped.

Function
REQ-011 SHALL hold results in a 2-entry FIFO of 2*width-bit words, with registered read/write pointers and a 2-bit occupancy count.
REQ-012 SHALL push ALU_OUT when OUT_VALID=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-013 SHALL drop the result and set OVERRUN=1 when OUT_VALID=1, the FIFO is full and no pop occurs that cycle; OVERRUN clears only on reset.
REQ-014 SHALL drive RES_READY=1 when occupancy < 2; it is registered and reflects the previous edge's occupancy.
REQ-015 SHALL use FSM states IDLE, SEND_LO, SEND_HI (plus SEND_CK, see Configuration).
REQ-016 SHALL move IDLE->SEND_LO on the edge where the FIFO is non-empty; TX_P_DATA=head[width-1:0] and TX_D_VALID=1 on the next cycle.
REQ-017 SHALL complete a byte transfer in any cycle where TX_D_VALID=1 and TX_BUSY=0; TX_P_DATA and TX_D_VALID SHALL stay stable while TX_BUSY=1.
REQ-018 SHALL move SEND_LO->SEND_HI on a transfer, presenting head[2*width-1:width] on the following cycle.
REQ-019 SHALL, on the SEND_HI transfer, pop the FIFO and go to SEND_LO if another entry remains, else go to IDLE with TX_D_VALID=0.
REQ-020 SHALL have a minimum latency of 1 cycle from an OUT_VALID push into an empty FIFO in IDLE to TX_D_VALID=1 with the low byte.
REQ-021 SHALL send bytes low-first, never reorder or duplicate results, and wrap pointers modulo 2.
REQ-022 SHALL, when a push and a pop occur in the same cycle, leave occupancy unchanged and write the pushed word to the freed slot.
REQ-023 SHALL register all outputs; OUT_VALID SHALL have no combinational path to any output.

Reset
REQ-024 SHALL, on a rising CLK edge with RST_n=0, set FSM=IDLE, pointers=0, occupancy=0, TX_P_DATA=0, TX_D_VALID=0, RES_READY=1 and OVERRUN=0.
REQ-025 SHALL, on reset mid-transfer, abandon the current word and discard all buffered results, with no partial byte emitted afterwards.
REQ-026 SHALL ignore OUT_VALID in any cycle where RST_n=0.

Configuration
REQ-027 SHALL, with macro ALU_RES_CHKSUM_EN defined, follow the SEND_HI transfer with state SEND_CK presenting low byte XOR high byte; the pop and the next-state decision move to the SEND_CK transfer.
REQ-028 SHALL, without ALU_RES_CHKSUM_EN, omit state SEND_CK and its XOR logic entirely, sending exactly two bytes per result.

Verification
REQ-029 SHALL cover single result: reset, OUT_VALID pulse with ALU_OUT=16'hA55A, TX_BUSY=0 -> TX_P_DATA 8'h5A then 8'hA5 on consecutive cycles, TX_D_VALID high for exactly 2 cycles (3 cycles with 8'hFF when ALU_RES_CHKSUM_EN is defined).
REQ-030 SHALL cover backpressure: ALU_OUT=16'h1234 with TX_BUSY=1 for 5 cycles -> TX_P_DATA held at 8'h34 with TX_D_VALID=1; after release, 8'h12 follows.
REQ-031 SHALL cover overrun: TX_BUSY=1, three pulses 16'h0001, 16'h0002, 16'h0003 -> RES_READY=0 after the second, OVERRUN=1 after the third; after release, output is 01,00,02,00 only.
REQ-032 SHALL cover simultaneous push/pop: FIFO full, OUT_VALID with 16'hBEEF in the same cycle as the final-byte transfer -> no OVERRUN, and 8'hEF,8'hBE are later emitted in order.
REQ-033 SHALL cover reset mid-operation: RST_n=0 while 8'hA5 is presented -> next cycle TX_D_VALID=0 and RES_READY=1; nothing is emitted until a new OUT_VALID.

Source files
------------

// File: rtl/alu_result_serializer.sv
// rtl/alu_result_serializer.sv - buffers ALU results in a 2-entry FIFO and emits them low byte first
// Optional macro ALU_RES_CHKSUM_EN appends a low^high checksum byte after each result.
module alu_result_serializer #(
  parameter int width = 8
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic [2*width-1:0] ALU_OUT,
  input  logic               OUT_VALID,
  input  logic               TX_BUSY,
  output logic [width-1:0]   TX_P_DATA,
  output logic               TX_D_VALID,
  output logic               RES_READY,
  output logic               OVERRUN
);

`ifdef ALU_RES_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI, SEND_CK} state_t;
  localparam state_t LAST_STATE = SEND_CK;
`else
  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;
  localparam state_t LAST_STATE = SEND_HI;
`endif

  state_t             state;
  logic [2*width-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;

  logic               xfer;
  logic               pop;
  logic               push;
  logic               more;
  logic [1:0]         count_nxt;
  logic [2*width-1:0] head;
  logic [2*width-1:0] next_word;

  always_comb begin
    xfer      = TX_D_VALID && !TX_BUSY;
    pop       = xfer && (state == LAST_STATE);
    push      = OUT_VALID && ((count != 2'd2) || pop);
    count_nxt = count + {1'b0, push} - {1'b0, pop};
    head      = mem[rd_ptr];
    // After a pop the next word is either the other buffered slot or the word arriving now.
    more      = (count == 2'd2) || push;
    next_word = (count == 2'd2) ? mem[~rd_ptr] : ALU_OUT;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state      <= IDLE;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      TX_P_DATA  <= '0;
      TX_D_VALID <= 1'b0;
      RES_READY  <= 1'b1;
      OVERRUN    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ALU_OUT;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count     <= count_nxt;
      RES_READY <= (count_nxt != 2'd2);
      if (OUT_VALID && (count == 2'd2) && !pop)
        OVERRUN <= 1'b1;

      case (state)
        IDLE: begin
          // Bypass the buffer when empty so the low byte appears one cycle after the pulse.
          if (count != 2'd0) begin
            state      <= SEND_LO;
            TX_P_DATA  <= head[width-1:0];
            TX_D_VALID <= 1'b1;
          end else if (OUT_VALID) begin
            state      <= SEND_LO;
            TX_P_DATA  <= ALU_OUT[width-1:0];
            TX_D_VALID <= 1'b1;
          end
        end
        SEND_LO: begin
          if (xfer) begin
            state     <= SEND_HI;
            TX_P_DATA <= head[2*width-1:width];
          end
        end
`ifdef ALU_RES_CHKSUM_EN
        SEND_HI: begin
          if (xfer) begin
            state     <= SEND_CK;
            TX_P_DATA <= head[width-1:0] ^ head[2*width-1:width];
          end
        end
`endif
        LAST_STATE: begin
          if (xfer) begin
            if (more) begin
              state     <= SEND_LO;
              TX_P_DATA <= next_word[width-1:0];
            end else begin
              state      <= IDLE;
              TX_D_VALID <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          TX_D_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// tb/tb_alu_result_serializer.sv - scoreboard bench for alu_result_serializer
module tb_alu_result_serializer;

`ifdef ALU_RES_CHKSUM_EN
  localparam int BPR = 3;
`else
  localparam int BPR = 2;
`endif

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_VALID = 1'b0;
  logic        TX_BUSY = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VALID;
  logic        RES_READY;
  logic        OVERRUN;

  alu_result_serializer #(.width(8)) dut (
    .CLK(CLK), .RST_n(RST_n), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_D_VALID(TX_D_VALID),
    .RES_READY(RES_READY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int       n_cmp = 0;
  int       n_fail = 0;
  logic [7:0] exp_q[$];
  int       sent_bytes = 0;
  int       accepted = 0;
  logic     exp_ovr = 1'b0;

  task automatic check(input string name, input int got, input int req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Reference: a result is accepted while fewer than two are pending, or when the
  // final byte of the oldest result completes in the same cycle.
  task automatic model_eval();
    bit fin;
    if (!RST_n) begin
      accepted = 0;
      exp_ovr  = 1'b0;
    end else if (OUT_VALID) begin
      fin = TX_D_VALID && !TX_BUSY && (sent_bytes % BPR == BPR - 1);
      if ((accepted - sent_bytes / BPR) < 2 || fin) begin
        accepted++;
        exp_q.push_back(ALU_OUT[7:0]);
        exp_q.push_back(ALU_OUT[15:8]);
        if (BPR == 3) exp_q.push_back(ALU_OUT[7:0] ^ ALU_OUT[15:8]);
      end else begin
        exp_ovr = 1'b1;
      end
    end
  endtask

  task automatic tick();
    #1 model_eval();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    tick();
    RST_n = 1'b1;
  endtask

  task automatic pulse(input logic [15:0] w);
    ALU_OUT   = w;
    OUT_VALID = 1'b1;
    tick();
    OUT_VALID = 1'b0;
  endtask

  always @(negedge CLK) begin
    logic [7:0] e;
    if (!RST_n) begin
      sent_bytes = 0;
      exp_q.delete();
    end else if (TX_D_VALID && !TX_BUSY) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got %0h required none", TX_P_DATA);
      end else begin
        e = exp_q.pop_front();
        if (TX_P_DATA !== e) begin
          n_fail++;
          $display("FAIL byte_%0d: got %0h required %0h", sent_bytes, TX_P_DATA, e);
        end
      end
      sent_bytes++;
    end
  end

  initial begin
    int  vcnt;
    bit  found;
    @(posedge CLK);
    #2;
    do_reset();
    check("rst_valid", TX_D_VALID, 0);
    check("rst_data", TX_P_DATA, 0);
    check("rst_ready", RES_READY, 1);
    check("rst_overrun", OVERRUN, 0);

    // Single result, with first-byte latency and valid length.
    pulse(16'hA55A);
    check("lat_valid", TX_D_VALID, 1);
    check("lat_data", TX_P_DATA, 8'h5A);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (TX_D_VALID) vcnt++;
      tick();
    end
    check("single_vcnt", vcnt, BPR);

    // Backpressure holds the low byte.
    TX_BUSY = 1'b1;
    pulse(16'h1234);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {TX_D_VALID, TX_P_DATA}, {1'b1, 8'h34});
      tick();
    end
    TX_BUSY = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("bp_drain", exp_q.size(), 0);

    // Overrun.
    TX_BUSY = 1'b1;
    pulse(16'h0001);
    pulse(16'h0002);
    check("ovr_ready", RES_READY, 0);
    pulse(16'h0003);
    check("ovr_flag", OVERRUN, 1);
    TX_BUSY = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("ovr_drain", exp_q.size(), 0);
    check("ovr_sticky", OVERRUN, 1);

    // Push into a full FIFO coinciding with the final-byte pop.
    do_reset();
    check("pp_rst_ovr", OVERRUN, 0);
    TX_BUSY = 1'b1;
    pulse(16'h1111);
    pulse(16'h2222);
    TX_BUSY = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (TX_D_VALID && (sent_bytes % BPR == BPR - 1)) found = 1;
      else tick();
    end
    check("pp_found", found, 1);
    pulse(16'hBEEF);
    check("pp_overrun", OVERRUN, 0);
    for (int i = 0; i < 12; i++) tick();
    check("pp_drain", exp_q.size(), 0);

    // Reset while the high byte is presented; OUT_VALID during reset is ignored.
    TX_BUSY = 1'b1;
    pulse(16'hA55A);
    TX_BUSY = 1'b0;
    tick();
    TX_BUSY = 1'b1;
    check("mid_hi", TX_P_DATA, 8'hA5);
    RST_n     = 1'b0;
    ALU_OUT   = 16'h7777;
    OUT_VALID = 1'b1;
    tick();
    OUT_VALID = 1'b0;
    RST_n     = 1'b1;
    check("mid_valid", TX_D_VALID, 0);
    check("mid_ready", RES_READY, 1);
    TX_BUSY = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (TX_D_VALID) vcnt++;
      tick();
    end
    check("mid_silent", vcnt, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      ALU_OUT   = 16'($urandom);
      OUT_VALID = ($urandom_range(0, 2) == 0);
      TX_BUSY   = ($urandom_range(0, 2) == 0);
      tick();
    end
    OUT_VALID = 1'b0;
    TX_BUSY   = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("rand_drain", exp_q.size(), 0);
    check("rand_overrun", OVERRUN, exp_ovr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
